// File: rtl/stk_slv_ctl.sv
// -----------------------------------------------------------------------------
// stk_slv_ctl
//
// Bridges a slave command port with no backpressure onto a single-outstanding
// stack command interface. Slave writes become stack PUSHes and slave reads
// become stack POPs. Commands are buffered in an N-entry FIFO and are issued
// strictly in arrival order. A slave command that arrives while the FIFO is
// full is dropped and sets a sticky overflow flag.
//
// Handshakes:
//   slave side : i_slv_cmd_vld is a one-cycle strobe with no backpressure;
//                o_slv_rsp_vld pulses for one cycle with the read data.
//   stack side : o_stk_cmd_vld/opcode/dat are held stable until the cycle in
//                which i_stk_cmd_ack=1 (transfer on that rising edge). A POP's
//                data arrives with i_stk_rsp_vld, either in the ack cycle or
//                any later cycle.
//
// Parameters:
//   W  stack data width (1..64)
//   N  command FIFO depth (power of two, >= 2)
//
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   i_slv_cmd_*        slave command strobe, read-not-write, write data
//   o_slv_rsp_*        slave read response strobe and zero-extended data
//   o_stk_cmd_*        stack command request, opcode (0 NOP/1 PUSH/2 POP), data
//   i_stk_cmd_ack      stack accepts the current command
//   i_stk_rsp_*        stack pop data strobe and data
//   o_ovf              sticky: a slave command was dropped
//   o_busy             FIFO non-empty or FSM not IDLE
// -----------------------------------------------------------------------------
module stk_slv_ctl #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_slv_cmd_vld,
    input  logic          i_slv_cmd_rnw,
    input  logic [63:0]   i_slv_cmd_dat,
    output logic          o_slv_rsp_vld,
    output logic [63:0]   o_slv_rsp_dat,
    output logic          o_stk_cmd_vld,
    output logic [1:0]    o_stk_cmd_opcode,
    output logic [W-1:0]  o_stk_cmd_dat,
    input  logic          i_stk_cmd_ack,
    input  logic          i_stk_rsp_vld,
    input  logic [W-1:0]  i_stk_rsp_dat,
    output logic          o_ovf,
    output logic          o_busy
);

    localparam int AW = $clog2(N);

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // FIFO storage: each entry is {rnw, data}
    logic [W:0]    mem [N];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [W:0]    head;
    logic          fifo_full;
    logic          enq;
    logic          deq;

    state_e        state;
    logic          hold_rnw;
    logic [63:0]   rsp_ext;

    // Upper write-data bits beyond W are intentionally ignored.
    logic          unused_slv_dat;
    assign unused_slv_dat = ^i_slv_cmd_dat;

    always_comb begin
        fifo_full = (count == (AW+1)'(N));
        enq       = i_slv_cmd_vld && !fifo_full;
        // Dequeue only from IDLE, so at most one command is ever outstanding.
        deq       = (state == IDLE) && (count != '0);
        head      = mem[rd_ptr];
    end

    always_comb begin
        rsp_ext          = '0;
        rsp_ext[W-1:0]   = i_stk_rsp_dat;
    end

    assign o_busy = (count != '0) || (state != IDLE);

    // FIFO data array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= {i_slv_cmd_rnw, i_slv_cmd_dat[W-1:0]};
        end
    end

    // FIFO pointers, occupancy and overflow flag
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_ovf  <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // Fullness is judged on the start-of-cycle count, so a drop still
            // happens even if the FSM dequeues in the same cycle.
            if (i_slv_cmd_vld && fifo_full) begin
                o_ovf <= 1'b1;
            end
        end
    end

    // Command FSM with registered stack and response outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state            <= IDLE;
            hold_rnw         <= 1'b0;
            o_stk_cmd_vld    <= 1'b0;
            o_stk_cmd_opcode <= OP_NOP;
            o_stk_cmd_dat    <= '0;
            o_slv_rsp_vld    <= 1'b0;
            o_slv_rsp_dat    <= '0;
        end else begin
            o_slv_rsp_vld <= 1'b0;
            o_slv_rsp_dat <= '0;
            case (state)
                IDLE: begin
                    if (deq) begin
                        hold_rnw         <= head[W];
                        o_stk_cmd_vld    <= 1'b1;
                        o_stk_cmd_opcode <= head[W] ? OP_POP : OP_PUSH;
                        o_stk_cmd_dat    <= head[W] ? '0 : head[W-1:0];
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_stk_cmd_ack) begin
                        o_stk_cmd_vld    <= 1'b0;
                        o_stk_cmd_opcode <= OP_NOP;
                        o_stk_cmd_dat    <= '0;
                        if (!hold_rnw) begin
                            state <= IDLE;
                        end else if (i_stk_rsp_vld) begin
                            // Stack answered in the ack cycle: skip WAIT.
                            o_slv_rsp_vld <= 1'b1;
                            o_slv_rsp_dat <= rsp_ext;
                            state         <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_stk_rsp_vld) begin
                        o_slv_rsp_vld <= 1'b1;
                        o_slv_rsp_dat <= rsp_ext;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
